// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed, checksummed byte
// stream and writes it as 32-bit big-endian words from address 0 upward.
module imem_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  word_count
);

    // Handshake: a byte moves only on a rising edge where byte_valid and
    // byte_ready are both 1; byte_valid may stay low indefinitely and
    // byte_ready depends only on the loader state, never on byte_valid.

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_BYTES,
        S_WRITE,
        S_CHK,
        S_DONE
    } state_t;

    state_t      state;
    logic [7:0]  word_total;
    logic [1:0]  byte_idx;
    logic [23:0] asm_q;
    logic [7:0]  csum;
    logic        accept;
    logic [7:0]  next_count;

    assign accept     = byte_valid && byte_ready;
    assign next_count = word_count + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= 8'd0;
            wr_data    <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= 8'd0;
            word_total <= 8'd0;
            byte_idx   <= 2'd0;
            asm_q      <= 24'd0;
            csum       <= 8'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LEN;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= 8'd0;
                        byte_idx   <= 2'd0;
                        csum       <= 8'd0;
                    end
                end

                S_LEN: begin
                    if (accept) begin
                        word_total <= byte_in;
                        state      <= (byte_in == 8'd0) ? S_CHK : S_BYTES;
                    end
                end

                S_BYTES: begin
                    if (accept) begin
                        csum     <= csum ^ byte_in;
                        byte_idx <= byte_idx + 2'd1;
                        // The fourth byte goes straight into wr_data so the
                        // write strobe lands on the very next cycle.
                        if (byte_idx == 2'd3) begin
                            state      <= S_WRITE;
                            byte_ready <= 1'b0;
                            wr_en      <= 1'b1;
                            wr_addr    <= word_count;
                            wr_data    <= {asm_q, byte_in};
                        end else begin
                            asm_q <= {asm_q[15:0], byte_in};
                        end
                    end
                end

                S_WRITE: begin
                    wr_en      <= 1'b0;
                    byte_ready <= 1'b1;
                    word_count <= next_count;
                    state      <= (next_count < word_total) ? S_BYTES : S_CHK;
                end

                S_CHK: begin
                    if (accept) begin
                        err        <= (byte_in != csum);
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        byte_ready <= 1'b0;
                        state      <= S_DONE;
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    wr_en      <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts the writes
// and final status, a monitor checks every write strobe against it.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  word_count;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stim_q[$];
    logic [39:0] exp_q[$];
    logic        exp_err;
    logic [7:0]  exp_cnt;
    logic        prev_wr_en = 1'b0;

    imem_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Model: length byte N, then 4N data bytes big-endian, then XOR checksum.
    task automatic build_model();
        int n;
        logic [7:0]  x;
        logic [31:0] d;
        n = int'(stim_q[0]);
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            d = {stim_q[1+4*w], stim_q[2+4*w], stim_q[3+4*w], stim_q[4+4*w]};
            x = x ^ stim_q[1+4*w] ^ stim_q[2+4*w] ^ stim_q[3+4*w] ^ stim_q[4+4*w];
            exp_q.push_back({8'(w), d});
        end
        exp_err = (stim_q[1+4*n] != x);
        exp_cnt = 8'(n);
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, required no write", wr_addr, wr_data);
                end else begin
                    check("write_addr_data", {24'd0, wr_addr, wr_data}, {24'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                check("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
                check("single_cycle_strobe", {63'd0, prev_wr_en}, 64'd0);
            end
            if (done) check("done_not_busy", {63'd0, busy}, 64'd0);
        end
        prev_wr_en = wr_en;
    end

    // driver: mode 0 = byte_valid held high, mode 1 = toggled every cycle
    task automatic drive(input int mode, input int pulse_cyc);
        int idx = 0;
        int cyc = 0;
        logic acc;
        while (idx < stim_q.size() && cyc < 4000) begin
            byte_valid = (mode == 0) || (cyc % 2 == 0);
            byte_in    = stim_q[idx];
            start      = (cyc == pulse_cyc);
            @(negedge clk);
            acc = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        if (idx < stim_q.size()) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: accepted %0d bytes, required %0d", idx, stim_q.size());
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("done_cleared", {63'd0, done}, 64'd0);
        check("err_cleared", {63'd0, err}, 64'd0);
        check("count_cleared", {56'd0, word_count}, 64'd0);
    endtask

    task automatic run_load(input string tag, input int mode, input int pulse_cyc);
        build_model();
        pulse_start();
        drive(mode, pulse_cyc);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_ready"}, {63'd0, byte_ready}, 64'd0);
        check({tag, "_err"}, {63'd0, err}, {63'd0, exp_err});
        check({tag, "_count"}, {56'd0, word_count}, {56'd0, exp_cnt});
        check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        // DONE must hold with no traffic
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_hold"}, {62'd0, done, err}, {62'd0, 1'b1, exp_err});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {63'd0, byte_ready}, 64'd0);
        check({tag, "_wr_en"}, {63'd0, wr_en}, 64'd0);
        check({tag, "_addr_data"}, {24'd0, wr_addr, wr_data}, 64'd0);
        check({tag, "_flags"}, {61'd0, busy, done, err}, 64'd0);
        check({tag, "_count"}, {56'd0, word_count}, 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b1;   // reset must win over start
        byte_valid = 1'b1;
        byte_in    = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        start      = 1'b0;
        byte_valid = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;
        check("idle_stays_idle", {62'd0, busy, byte_ready}, 64'd0);

        // two words, good checksum
        stim_q = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
        build_model();
        check("model_w0", {24'd0, exp_q[0]}, {24'd0, 8'h00, 32'h12345678});
        check("model_w1", {24'd0, exp_q[1]}, {24'd0, 8'h01, 32'h9ABCDEF0});
        check("model_err", {63'd0, exp_err}, 64'd0);
        exp_q.delete();
        run_load("two_words", 0, -1);
        check("two_words_literal", {54'd0, done, err, word_count}, {54'd0, 1'b1, 1'b0, 8'd2});

        // bad checksum, restart from DONE
        stim_q = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF};
        run_load("bad_sum", 0, -1);
        check("bad_sum_literal", {54'd0, done, err, word_count}, {54'd0, 1'b1, 1'b1, 8'd1});

        // empty program
        stim_q = '{8'h00, 8'h00};
        run_load("empty", 0, -1);
        check("empty_literal", {54'd0, done, err, word_count}, {54'd0, 1'b1, 1'b0, 8'd0});

        // stalled stream
        stim_q = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
        run_load("stalled", 1, -1);
        check("stalled_literal", {54'd0, done, err, word_count}, {54'd0, 1'b1, 1'b0, 8'd1});

        // start pulse during BYTES must be ignored
        stim_q = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40,
                   8'hFF, 8'h00, 8'hFF, 8'h00, 8'h44};
        run_load("start_in_bytes", 0, 3);
        check("start_in_bytes_literal", {54'd0, done, err, word_count}, {54'd0, 1'b1, 1'b0, 8'd3});

        // reset after two data bytes aborts without a write
        stim_q = '{8'h01, 8'h11, 8'h22};
        pulse_start();
        drive(0, -1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("abort");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_quiet", {62'd0, busy, byte_ready}, 64'd0);

        stim_q = '{8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
        run_load("after_abort", 0, -1);
        check("after_abort_literal", {54'd0, done, err, word_count}, {54'd0, 1'b1, 1'b0, 8'd1});

        check("no_pending_writes", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have port: clk  input  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  one-cycle pulse requesting a new program load.
REQ-004 SHALL have port: byte_in  input  8  incoming program stream byte.
REQ-005 SHALL have port: byte_valid  input  1  byte_in holds a valid byte.
REQ-006 SHALL have port: byte_ready  output  1  loader accepts byte_in this cycle.
REQ-007 SHALL have port: wr_en  output  1  instruction-memory write strobe.
REQ-008 SHALL have port: wr_addr  output  8  instruction-memory word address, same space as the fetch line_no.
REQ-009 SHALL have port: wr_data  output  32  instruction word to write.
REQ-010 SHALL have port: busy  output  1  load in progress; fetch unit held.
REQ-011 SHALL have port: done  output  1  load finished; fetch may run from address 0.
REQ-012 SHALL have port: err  output  1  checksum mismatch on last load.
REQ-013 SHALL have port: word_count  output  8  number of words written by last or current load.

Function
REQ-014 SHALL implement states IDLE, LEN, BYTES, WRITE, CHK, DONE.
REQ-015 SHALL transfer a byte only on a cycle with byte_valid=1 and byte_ready=1 (handshake).
REQ-016 SHALL drive byte_ready=1 only in LEN, BYTES, CHK; 0 in IDLE, WRITE, DONE.
REQ-017 SHALL, from IDLE or DONE, move to LEN on start=1, clearing done, err, word_count, byte index, checksum; busy=1 from next cycle.
REQ-018 SHALL ignore start while in LEN, BYTES, WRITE, CHK.
REQ-019 SHALL, in LEN, latch the accepted byte as word total N; N=0 goes directly to CHK, else to BYTES.
REQ-020 SHALL, in BYTES, assemble 4 accepted bytes MSB-first (first byte -> wr_data[31:24]) then move to WRITE.
REQ-021 SHALL, in WRITE, assert wr_en for exactly one cycle with wr_addr=word_count and assembled wr_data, then increment word_count.
REQ-022 SHALL leave WRITE to BYTES if word_count (post-increment) < N, else to CHK; N=255 max, word_count never wraps.
REQ-023 SHALL keep a running XOR of all data bytes (count byte excluded), initial 8'h00.
REQ-024 SHALL, in CHK, compare accepted byte to running XOR; set err=1 on mismatch; move to DONE.
REQ-025 SHALL hold done=1, busy=0, err and word_count stable in DONE until next start.
REQ-026 SHALL hold wr_en=0 in every state except WRITE; wr_addr/wr_data hold last values otherwise.
REQ-027 SHALL stall in any accepting state indefinitely while byte_valid=0, with no output change.
REQ-028 SHALL complete an N-word load with no stalls in 1+5N+1 accepted/write cycles after LEN entry.

Reset
REQ-029 SHALL, on rising clk with rst_n=0, enter IDLE with byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, word_count=0.
REQ-030 SHALL, on reset mid-load, abort with no further wr_en pulse; already-written words are not retracted.
REQ-031 SHALL give rst_n priority over start and byte_valid in the same cycle.

Verification
REQ-032 Reset then start, stream 02,12,34,56,78,9A,BC,DE,F0,checksum 00 -> wr_en at addr 0 data 12345678, addr 1 data 9ABCDEF0; done=1, err=0, word_count=2.
REQ-033 Start, stream 01,AA,BB,CC,DD,FF -> one write addr 0 data AABBCCDD; done=1, err=1 (expected 00).
REQ-034 Start, stream 00,00 -> no wr_en; done=1, err=0, word_count=0.
REQ-035 Load N=1 with byte_valid toggled 1/0 every cycle -> same result as unstalled; byte_ready=0 during WRITE cycle.
REQ-036 rst_n=0 after 2 data bytes of N=1 load -> IDLE, no wr_en, all outputs reset values; second start completes normally.
REQ-037 start pulse during BYTES -> ignored, word_count and addresses unaffected.
